// File: rtl/vga_timing_pkg.sv
// Default 640x480 (800x525 total) VGA mode constants, shared by the sync
// generator, the porch stage and the pattern logic.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 18;
    localparam int VGA_H_PULSE  = 92;
    localparam int VGA_H_BACK   = 50;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_PULSE  = 2;
    localparam int VGA_V_BACK   = 33;

    localparam int VGA_CNT_W    = 10;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_PULSE + VGA_H_BACK;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_PULSE + VGA_V_BACK;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus registered active/sync
// decode of the post-advance position.
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FRONT  = 18,
    parameter int PULSE  = 92,
    parameter int BACK   = 50,
    parameter int CNT_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             active,
    output logic             sync
);

    localparam logic [CNT_W:0]   TOTAL      = (CNT_W+1)'(ACTIVE + FRONT + PULSE + BACK);
    localparam logic [CNT_W:0]   ACT_END    = (CNT_W+1)'(ACTIVE);
    localparam logic [CNT_W:0]   SYNC_START = (CNT_W+1)'(ACTIVE + FRONT);
    localparam logic [CNT_W:0]   SYNC_END   = (CNT_W+1)'(ACTIVE + FRONT + PULSE);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - (CNT_W+1)'(1));

    logic [CNT_W-1:0] pos;
    logic [CNT_W-1:0] pos_next;
    logic [CNT_W:0]   pos_next_ext;

    always_comb begin
        wrap         = advance && (pos == LAST);
        pos_next     = (pos == LAST) ? '0 : pos + CNT_W'(1);
        pos_next_ext = {1'b0, pos_next};
    end

    // Internal position parks on the last value so the first advance lands
    // on 0, while the visible count reads 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos    <= LAST;
            count  <= '0;
            active <= 1'b0;
            sync   <= 1'b1;
        end else if (advance) begin
            pos    <= pos_next;
            count  <= pos_next;
            active <= (pos_next_ext < ACT_END);
            sync   <= !((pos_next_ext >= SYNC_START) && (pos_next_ext < SYNC_END));
        end
    end

endmodule

// File: rtl/vga_sync_pulses_gen.sv
// Free-running VGA raster timing generator: H/V sync, active flag,
// column/row position and frame-start strobe, one pixel per enabled clock.
module vga_sync_pulses_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FRONT  = VGA_H_FRONT,
    parameter int H_PULSE  = VGA_H_PULSE,
    parameter int H_BACK   = VGA_H_BACK,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FRONT  = VGA_V_FRONT,
    parameter int V_PULSE  = VGA_V_PULSE,
    parameter int V_BACK   = VGA_V_BACK,
    parameter int CNT_W    = VGA_CNT_W
) (
    input  logic             CLK,
    input  logic             i_Rst_L,
    input  logic             i_En,
    output logic             o_H_Sync,
    output logic             o_V_Sync,
    output logic             o_Active,
    output logic [CNT_W-1:0] o_Col_Count,
    output logic [CNT_W-1:0] o_Row_Count,
    output logic             o_Frame_Start
);

    logic h_wrap;
    logic v_wrap;
    logic h_active;
    logic v_active;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .PULSE  (H_PULSE),
        .BACK   (H_BACK),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .clk     (CLK),
        .rst_n   (i_Rst_L),
        .advance (i_En),
        .count   (o_Col_Count),
        .wrap    (h_wrap),
        .active  (h_active),
        .sync    (o_H_Sync)
    );

    // Row advances only on the edge where the column wraps.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .PULSE  (V_PULSE),
        .BACK   (V_BACK),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .clk     (CLK),
        .rst_n   (i_Rst_L),
        .advance (h_wrap),
        .count   (o_Row_Count),
        .wrap    (v_wrap),
        .active  (v_active),
        .sync    (o_V_Sync)
    );

    assign o_Active = h_active & v_active;

    always_ff @(posedge CLK or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Frame_Start <= 1'b0;
        end else begin
            o_Frame_Start <= h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_sync_pulses_gen.sv
// Directed bench for vga_sync_pulses_gen: default 800x525 mode for line-level
// behaviour, a 16x7 override instance for whole-frame behaviour.
module tb_vga_sync_pulses_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-mode instance
    logic       rst_n, en;
    logic       hs, vs, act, fs;
    logic [9:0] col, row;

    // small-mode instance (H 8/2/3/3 -> 16, V 4/1/1/1 -> 7)
    logic       rst_s, en_s;
    logic       hs_s, vs_s, act_s, fs_s;
    logic [3:0] col_s, row_s;

    int checks = 0;
    int errors = 0;

    int d_col, d_row;   // expected default-mode position
    int m_col, m_row;   // expected small-mode position

    vga_sync_pulses_gen dut (
        .CLK           (clk),
        .i_Rst_L       (rst_n),
        .i_En          (en),
        .o_H_Sync      (hs),
        .o_V_Sync      (vs),
        .o_Active      (act),
        .o_Col_Count   (col),
        .o_Row_Count   (row),
        .o_Frame_Start (fs)
    );

    vga_sync_pulses_gen #(
        .H_ACTIVE (8), .H_FRONT (2), .H_PULSE (3), .H_BACK (3),
        .V_ACTIVE (4), .V_FRONT (1), .V_PULSE (1), .V_BACK (1),
        .CNT_W    (4)
    ) dut_s (
        .CLK           (clk),
        .i_Rst_L       (rst_s),
        .i_En          (en_s),
        .o_H_Sync      (hs_s),
        .o_V_Sync      (vs_s),
        .o_Active      (act_s),
        .o_Col_Count   (col_s),
        .o_Row_Count   (row_s),
        .o_Frame_Start (fs_s)
    );

    function automatic void d_advance();
        if (d_col == 799) begin
            d_col = 0;
            d_row = (d_row == 524) ? 0 : d_row + 1;
        end else begin
            d_col = d_col + 1;
        end
    endfunction

    function automatic void m_advance();
        if (m_col == 15) begin
            m_col = 0;
            m_row = (m_row == 6) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1;
        rst_s = 1'b0; en_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({hs, vs, act, fs} !== 4'b1100 || col !== 10'd0 || row !== 10'd0) begin
            errors++;
            $display("FAIL reset_idle: hs=%b vs=%b act=%b fs=%b col=%0d row=%0d, need 1 1 0 0 0 0",
                     hs, vs, act, fs, col, row);
        end
        checks++;
        if ({hs_s, vs_s, act_s, fs_s} !== 4'b1100 || col_s !== 4'd0 || row_s !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle_small: hs=%b vs=%b act=%b fs=%b col=%0d row=%0d, need 1 1 0 0 0 0",
                     hs_s, vs_s, act_s, fs_s, col_s, row_s);
        end
    endtask

    task automatic test_first_pixel();
        rst_n = 1'b1;
        @(posedge clk); #1;
        d_col = 0; d_row = 0;
        checks++;
        if (col !== 10'd0 || row !== 10'd0 || act !== 1'b1 || fs !== 1'b1 || hs !== 1'b1 || vs !== 1'b1) begin
            errors++;
            $display("FAIL first_pixel: col=%0d row=%0d act=%b fs=%b hs=%b vs=%b, need 0 0 1 1 1 1",
                     col, row, act, fs, hs, vs);
        end
        @(posedge clk); #1;
        d_col = 1;
        checks++;
        if (col !== 10'd1 || row !== 10'd0 || act !== 1'b1 || fs !== 1'b0) begin
            errors++;
            $display("FAIL second_pixel: col=%0d row=%0d act=%b fs=%b, need 1 0 1 0",
                     col, row, act, fs);
        end
    endtask

    task automatic test_line();
        int low_cnt = 0;
        int first_low = -1;
        int last_low = -1;
        logic exp_hs, exp_act;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            d_advance();
            exp_hs  = !(d_col >= 658 && d_col <= 749);
            exp_act = (d_col < 640) && (d_row < 480);
            checks++;
            if (col !== 10'(d_col) || row !== 10'(d_row) || hs !== exp_hs || act !== exp_act ||
                vs !== 1'b1 || fs !== 1'b0) begin
                errors++;
                $display("FAIL line_pixel: col=%0d row=%0d hs=%b act=%b vs=%b fs=%b, need %0d %0d %b %b 1 0",
                         col, row, hs, act, vs, fs, d_col, d_row, exp_hs, exp_act);
            end
            if (hs === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = int'(col);
                last_low = int'(col);
            end
        end
        checks++;
        if (low_cnt != 92 || first_low != 658 || last_low != 749) begin
            errors++;
            $display("FAIL hsync_window: width=%0d first=%0d last=%0d, need 92 658 749",
                     low_cnt, first_low, last_low);
        end
        checks++;
        if (row !== 10'd1) begin
            errors++;
            $display("FAIL row_increment: row=%0d, need 1", row);
        end
    endtask

    task automatic test_enable_pattern();
        for (int i = 0; i < 60; i++) begin
            en = (i % 3 == 0);
            @(posedge clk); #1;
            if (en) d_advance();
            checks++;
            if (col !== 10'(d_col) || row !== 10'(d_row) || fs !== 1'b0) begin
                errors++;
                $display("FAIL enable_pattern: cycle=%0d col=%0d row=%0d fs=%b, need %0d %0d 0",
                         i, col, row, fs, d_col, d_row);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_async_reset();
        bit found = 0;
        for (int i = 0; i < 1600; i++) begin
            if (col === 10'd700) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!found || hs !== 1'b0 || act !== 1'b0) begin
            errors++;
            $display("FAIL reach_mid_pulse: found=%0d col=%0d hs=%b act=%b, need 1 700 0 0",
                     found, col, hs, act);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({hs, vs, act, fs} !== 4'b1100 || col !== 10'd0 || row !== 10'd0) begin
            errors++;
            $display("FAIL async_reset_now: hs=%b vs=%b act=%b fs=%b col=%0d row=%0d, need 1 1 0 0 0 0",
                     hs, vs, act, fs, col, row);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({hs, vs, act, fs} !== 4'b1100 || col !== 10'd0 || row !== 10'd0) begin
            errors++;
            $display("FAIL async_reset_hold: hs=%b vs=%b act=%b fs=%b col=%0d row=%0d, need 1 1 0 0 0 0",
                     hs, vs, act, fs, col, row);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (col !== 10'd0 || row !== 10'd0 || act !== 1'b1 || fs !== 1'b1 || hs !== 1'b1) begin
            errors++;
            $display("FAIL restart_pixel: col=%0d row=%0d act=%b fs=%b hs=%b, need 0 0 1 1 1",
                     col, row, act, fs, hs);
        end
        @(posedge clk); #1;
        checks++;
        if (col !== 10'd1 || fs !== 1'b0) begin
            errors++;
            $display("FAIL restart_next: col=%0d fs=%b, need 1 0", col, fs);
        end
    endtask

    task automatic test_small_frame();
        int vs_low = 0;
        int fs_cnt = 0;
        int last_fs = -1;
        logic exp_hs, exp_vs, exp_act, exp_fs;
        rst_s = 1'b1;
        en_s  = 1'b1;
        m_col = 15; m_row = 6;
        for (int i = 0; i < 224; i++) begin
            @(posedge clk); #1;
            m_advance();
            exp_hs  = !(m_col >= 10 && m_col <= 12);
            exp_vs  = (m_row != 5);
            exp_act = (m_col < 8) && (m_row < 4);
            exp_fs  = (m_col == 0) && (m_row == 0);
            checks++;
            if (col_s !== 4'(m_col) || row_s !== 4'(m_row) || hs_s !== exp_hs || vs_s !== exp_vs ||
                act_s !== exp_act || fs_s !== exp_fs) begin
                errors++;
                $display("FAIL small_frame: i=%0d col=%0d row=%0d hs=%b vs=%b act=%b fs=%b, need %0d %0d %b %b %b %b",
                         i, col_s, row_s, hs_s, vs_s, act_s, fs_s,
                         m_col, m_row, exp_hs, exp_vs, exp_act, exp_fs);
            end
            if (vs_s === 1'b0) vs_low++;
            if (fs_s === 1'b1) begin
                fs_cnt++;
                if (last_fs >= 0) begin
                    checks++;
                    if (i - last_fs != 112) begin
                        errors++;
                        $display("FAIL frame_period: got %0d cycles, need 112", i - last_fs);
                    end
                end
                last_fs = i;
            end
        end
        checks++;
        if (vs_low != 32 || fs_cnt != 2) begin
            errors++;
            $display("FAIL small_vsync_count: vs_low=%0d fs=%0d, need 32 2", vs_low, fs_cnt);
        end
    endtask

    task automatic test_small_enable_pattern();
        int fs_cnt = 0;
        logic exp_fs;
        for (int i = 0; i < 340; i++) begin
            en_s = (i % 3 == 0);
            @(posedge clk); #1;
            if (en_s) m_advance();
            exp_fs = en_s && (m_col == 0) && (m_row == 0);
            checks++;
            if (col_s !== 4'(m_col) || row_s !== 4'(m_row) || fs_s !== exp_fs) begin
                errors++;
                $display("FAIL small_enable_pattern: i=%0d col=%0d row=%0d fs=%b, need %0d %0d %b",
                         i, col_s, row_s, fs_s, m_col, m_row, exp_fs);
            end
            if (fs_s === 1'b1) fs_cnt++;
        end
        checks++;
        if (fs_cnt != 2) begin
            errors++;
            $display("FAIL small_fs_width: fs high cycles=%0d, need 2", fs_cnt);
        end
        en_s = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0;
        rst_s = 1'b0; en_s = 1'b0;
        d_col = 0; d_row = 0;
        m_col = 15; m_row = 6;
        test_reset();
        test_first_pixel();
        test_line();
        test_enable_pattern();
        test_async_reset();
        test_small_frame();
        test_small_enable_pattern();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
